// File: rtl/usb_link_pkg.sv
// rtl/usb_link_pkg.sv - shared FT245 link types, frame constants and timing defaults
package usb_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RECOVER = 3'd5
    } link_state_t;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
    localparam int         FRAME_BYTES         = 4;

    // Bus timing defaults, shared with the read side of the link
    localparam int unsigned DEFAULT_SETUP_CYCLES   = 2;
    localparam int unsigned DEFAULT_STROBE_CYCLES  = 3;
    localparam int unsigned DEFAULT_HOLD_CYCLES    = 1;
    localparam int unsigned DEFAULT_RECOVER_CYCLES = 4;

    function automatic logic [7:0] frame_checksum(input logic [7:0] hdr,
                                                  input logic [7:0] b1,
                                                  input logic [7:0] b2);
        return hdr ^ b1 ^ b2;
    endfunction

endpackage

// File: rtl/ft245_write_strobe.sv
// rtl/ft245_write_strobe.sv - single-byte FT245 write sequencer with bus arbitration
module ft245_write_strobe
    import usb_link_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = DEFAULT_SETUP_CYCLES,
    parameter int unsigned STROBE_CYCLES  = DEFAULT_STROBE_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
    parameter int unsigned RECOVER_CYCLES = DEFAULT_RECOVER_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       more,
    input  logic [7:0] data,
    input  logic       rx_busy,
    input  logic       txe_sync,
    output logic       wr_n,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       done,
    output logic [2:0] state_out
);

    localparam logic [3:0] SETUP_LIM   = 4'(SETUP_CYCLES);
    localparam logic [3:0] STROBE_LIM  = 4'(STROBE_CYCLES);
    localparam logic [3:0] HOLD_LIM    = 4'(HOLD_CYCLES);
    localparam logic [3:0] RECOVER_LIM = 4'(RECOVER_CYCLES);

    link_state_t state;
    link_state_t next_state;
    logic [3:0]  cnt;
    logic [3:0]  lim;
    logic        phase_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            data_out <= 8'h00;
        end else begin
            state <= next_state;
            if (state != next_state || state == ST_IDLE || state == ST_WAIT)
                cnt <= 4'd0;
            else
                cnt <= cnt + 4'd1;
            if (state == ST_WAIT && next_state == ST_SETUP)
                data_out <= data;
        end
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        lim        = 4'd0;
        case (state)
            ST_SETUP:   lim = SETUP_LIM;
            ST_STROBE:  lim = STROBE_LIM;
            ST_HOLD:    lim = HOLD_LIM;
            ST_RECOVER: lim = RECOVER_LIM;
            default:    lim = 4'd0;
        endcase
        // A zero-length phase still occupies one cycle
        phase_done = ({1'b0, cnt} + 5'd1) >= {1'b0, lim};
        case (state)
            ST_IDLE:    if (start) next_state = ST_WAIT;
            ST_WAIT:    if (!txe_sync && !rx_busy) next_state = ST_SETUP;
            ST_SETUP:   if (phase_done) next_state = ST_STROBE;
            ST_STROBE:  if (phase_done) next_state = ST_HOLD;
            ST_HOLD:    if (phase_done) next_state = ST_RECOVER;
            ST_RECOVER: if (phase_done) begin
                done       = 1'b1;
                next_state = more ? ST_WAIT : ST_IDLE;
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    assign wr_n      = (state != ST_STROBE);
    assign data_oe   = (state == ST_SETUP) || (state == ST_STROBE) ||
                       (state == ST_HOLD && HOLD_CYCLES != 0);
    assign state_out = state;

endmodule

// File: rtl/usb_tx_controller.sv
// rtl/usb_tx_controller.sv - packs panel switches into 4-byte status frames for the FT245 link
module usb_tx_controller
    import usb_link_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = DEFAULT_SETUP_CYCLES,
    parameter int unsigned STROBE_CYCLES  = DEFAULT_STROBE_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
    parameter int unsigned RECOVER_CYCLES = DEFAULT_RECOVER_CYCLES,
    parameter logic [7:0]  HEADER_BYTE    = DEFAULT_HEADER_BYTE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] panel_switches_raw,
    input  logic        report_req,
    input  logic        rx_busy,
    input  logic        txe_n_raw,
    output logic        wr_n,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        tx_busy,
    output logic [15:0] frames_sent,
    output logic [2:0]  state_out
);

    localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

    logic        txe_s1, txe_sync;
    logic [15:0] sw_s1, sw_sync, sw_prev, frame_sw;
    logic        pending;
    logic [1:0]  byte_idx;
    logic [7:0]  cur_byte;
    logic        latch, done;

    assign latch = (state_out == ST_IDLE) && pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txe_s1      <= 1'b1;
            txe_sync    <= 1'b1;
            sw_s1       <= 16'h0000;
            sw_sync     <= 16'h0000;
            sw_prev     <= 16'h0000;
            frame_sw    <= 16'h0000;
            pending     <= 1'b0;
            byte_idx    <= 2'd0;
            tx_busy     <= 1'b0;
            frames_sent <= 16'h0000;
        end else begin
            txe_s1   <= txe_n_raw;
            txe_sync <= txe_s1;
            sw_s1    <= panel_switches_raw;
            sw_sync  <= sw_s1;
            // A request arriving in the latch cycle still earns one more frame
            if (latch)
                pending <= report_req;
            else
                pending <= pending | report_req | (sw_sync != sw_prev);
            if (latch) begin
                frame_sw <= sw_sync;
                sw_prev  <= sw_sync;
                byte_idx <= 2'd0;
                tx_busy  <= 1'b1;
            end else if (done) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == LAST_IDX) begin
                    tx_busy     <= 1'b0;
                    frames_sent <= frames_sent + 16'd1;
                end
            end
        end
    end

    always_comb begin
        cur_byte = HEADER_BYTE;
        case (byte_idx)
            2'd0: cur_byte = HEADER_BYTE;
            2'd1: cur_byte = frame_sw[7:0];
            2'd2: cur_byte = frame_sw[15:8];
            2'd3: cur_byte = frame_checksum(HEADER_BYTE, frame_sw[7:0], frame_sw[15:8]);
            default: cur_byte = HEADER_BYTE;
        endcase
    end

    ft245_write_strobe #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .STROBE_CYCLES (STROBE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .RECOVER_CYCLES(RECOVER_CYCLES)
    ) u_strobe (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (latch),
        .more     (byte_idx != LAST_IDX),
        .data     (cur_byte),
        .rx_busy  (rx_busy),
        .txe_sync (txe_sync),
        .wr_n     (wr_n),
        .data_out (data_out),
        .data_oe  (data_oe),
        .done     (done),
        .state_out(state_out)
    );

endmodule

// File: tb/tb_usb_tx_controller.sv
// tb/tb_usb_tx_controller.sv - self-checking bench for usb_tx_controller
module tb_usb_tx_controller;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] panel_switches_raw;
    logic        report_req;
    logic        rx_busy;
    logic        txe_n_raw;
    logic        wr_n;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        tx_busy;
    logic [15:0] frames_sent;
    logic [2:0]  state_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          bad_strobe = 0;
    logic [15:0] exp_frames = 16'd0;
    logic [15:0] cur_sw = 16'h0000;

    typedef struct {
        logic [7:0] data;
        int         setup;
        int         strobe;
        int         hold;
        bit         stable;
    } rec_t;

    rec_t rec_q[$];
    rec_t cur;
    bit   in_byte = 0;
    bit   seen_low = 0;

    always #10 clk = ~clk;

    usb_tx_controller dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .panel_switches_raw(panel_switches_raw),
        .report_req        (report_req),
        .rx_busy           (rx_busy),
        .txe_n_raw         (txe_n_raw),
        .wr_n              (wr_n),
        .data_out          (data_out),
        .data_oe           (data_oe),
        .tx_busy           (tx_busy),
        .frames_sent       (frames_sent),
        .state_out         (state_out)
    );

    // Bus observer: one record per data_oe window
    always @(negedge clk) begin
        if (!reset_n) begin
            in_byte = 0;
        end else if (data_oe === 1'b1) begin
            if (!in_byte) begin
                in_byte    = 1;
                seen_low   = 0;
                cur.data   = data_out;
                cur.setup  = 0;
                cur.strobe = 0;
                cur.hold   = 0;
                cur.stable = 1;
            end
            if (data_out !== cur.data) cur.stable = 0;
            if (wr_n === 1'b0) begin
                cur.strobe++;
                seen_low = 1;
            end else if (seen_low) cur.hold++;
            else cur.setup++;
        end else if (in_byte) begin
            in_byte = 0;
            rec_q.push_back(cur);
        end
        if (reset_n && wr_n === 1'b0 && data_oe !== 1'b1) bad_strobe++;
    end

    function automatic logic [7:0] model_byte(input logic [15:0] sw, input int k);
        logic [7:0] b[4];
        b[0] = HDR;
        b[1] = sw[7:0];
        b[2] = sw[15:8];
        b[3] = b[0] ^ b[1] ^ b[2];
        return b[k];
    endfunction

    function automatic logic [15:0] fresh_sw(input logic [15:0] prev);
        logic [15:0] v;
        v = 16'($urandom);
        if (v == prev) v = v ^ 16'h0001;
        if (v == 16'h0000) v = 16'h0101;
        return v;
    endfunction

    task automatic wait_frames(input logic [15:0] target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frames_sent === target) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_busy(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        reset_n = 0;
        panel_switches_raw = 16'h0000;
        report_req = 0;
        rx_busy = 0;
        txe_n_raw = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (wr_n !== 1'b1) begin n_fail++; $display("FAIL reset_wr_n: got %b expected 1", wr_n); end
        n_checks++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b expected 0", data_oe); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        n_checks++; if (frames_sent !== 16'h0000) begin n_fail++; $display("FAIL reset_frames: got %h expected 0000", frames_sent); end
        n_checks++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        reset_n = 1;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (data_oe !== 1'b0 || wr_n !== 1'b1 || tx_busy !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles expected 0", seen); end
        n_checks++; if (rec_q.size() != 0) begin n_fail++; $display("FAIL idle_no_bytes: got %0d expected 0", rec_q.size()); end
    endtask

    task automatic test_first_frame();
        bit ok;
        int busy_cycles;
        rec_q.delete();
        cur_sw = 16'h3C81;
        panel_switches_raw = cur_sw;
        wait_busy(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_start: got timeout expected tx_busy=1"); end
        busy_cycles = 0;
        while (tx_busy === 1'b1 && busy_cycles < 1000) begin
            busy_cycles++;
            @(negedge clk);
        end
        exp_frames = exp_frames + 16'd1;
        n_checks++; if (busy_cycles != 44) begin n_fail++; $display("FAIL frame_duration: got %0d expected 44", busy_cycles); end
        n_checks++; if (frames_sent !== exp_frames) begin n_fail++; $display("FAIL frame_count: got %0d expected %0d", frames_sent, exp_frames); end
        n_checks++;
        if (rec_q.size() != 4) begin
            n_fail++; $display("FAIL frame_len: got %0d expected 4", rec_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (rec_q[i].data !== model_byte(cur_sw, i)) begin n_fail++; $display("FAIL frame_byte%0d: got %h expected %h", i, rec_q[i].data, model_byte(cur_sw, i)); end
                n_checks++; if (rec_q[i].setup != 2) begin n_fail++; $display("FAIL setup%0d: got %0d expected 2", i, rec_q[i].setup); end
                n_checks++; if (rec_q[i].strobe != 3) begin n_fail++; $display("FAIL strobe%0d: got %0d expected 3", i, rec_q[i].strobe); end
                n_checks++; if (rec_q[i].hold != 1) begin n_fail++; $display("FAIL hold%0d: got %0d expected 1", i, rec_q[i].hold); end
                n_checks++; if (!rec_q[i].stable) begin n_fail++; $display("FAIL stable%0d: got unstable expected stable", i); end
            end
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        for (int r = 0; r < 4; r++) begin
            rec_q.delete();
            cur_sw = fresh_sw(cur_sw);
            panel_switches_raw = cur_sw;
            exp_frames = exp_frames + 16'd1;
            wait_frames(exp_frames, 300, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_count%0d: got %0d expected %0d", r, frames_sent, exp_frames); end
            repeat (5) @(negedge clk);
            n_checks++;
            if (rec_q.size() != 4) begin
                n_fail++; $display("FAIL rand_len%0d: got %0d expected 4", r, rec_q.size());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    n_checks++; if (rec_q[i].data !== model_byte(cur_sw, i)) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h expected %h", r, i, rec_q[i].data, model_byte(cur_sw, i)); end
                end
            end
        end
    endtask

    task automatic test_txe_stall();
        bit ok;
        rec_q.delete();
        cur_sw = fresh_sw(cur_sw);
        panel_switches_raw = cur_sw;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rec_q.size() == 2) begin ok = 1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_reach: got %0d bytes expected 2", rec_q.size()); end
        txe_n_raw = 1;
        repeat (100) @(negedge clk);
        n_checks++; if (state_out !== 3'd1) begin n_fail++; $display("FAIL stall_state: got %0d expected 1", state_out); end
        n_checks++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL stall_oe: got %b expected 0", data_oe); end
        n_checks++; if (rec_q.size() != 2) begin n_fail++; $display("FAIL stall_bytes: got %0d expected 2", rec_q.size()); end
        txe_n_raw = 0;
        exp_frames = exp_frames + 16'd1;
        wait_frames(exp_frames, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", frames_sent, exp_frames); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (rec_q.size() != 4) begin
            n_fail++; $display("FAIL stall_len: got %0d expected 4", rec_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (rec_q[i].data !== model_byte(cur_sw, i)) begin n_fail++; $display("FAIL stall_byte%0d: got %h expected %h", i, rec_q[i].data, model_byte(cur_sw, i)); end
            end
        end
    endtask

    task automatic test_rx_busy();
        bit ok;
        rec_q.delete();
        rx_busy = 1;
        txe_n_raw = 1;
        cur_sw = fresh_sw(cur_sw);
        panel_switches_raw = cur_sw;
        wait_busy(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rx_start: got timeout expected tx_busy=1"); end
        repeat (40) @(negedge clk);
        n_checks++; if (state_out !== 3'd1) begin n_fail++; $display("FAIL rx_wait_state: got %0d expected 1", state_out); end
        txe_n_raw = 0;
        repeat (20) @(negedge clk);
        n_checks++; if (data_oe !== 1'b0 || rec_q.size() != 0) begin n_fail++; $display("FAIL rx_block: got oe=%b bytes=%0d expected oe=0 bytes=0", data_oe, rec_q.size()); end
        rx_busy = 0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_n === 1'b0) begin ok = 1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rx_strobe: got timeout expected wr_n=0"); end
        rx_busy = 1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rec_q.size() == 1) begin ok = 1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rx_complete: got %0d bytes expected 1", rec_q.size());
        end else begin
            n_checks++; if (rec_q[0].data !== HDR || rec_q[0].strobe != 3 || rec_q[0].hold != 1) begin n_fail++; $display("FAIL rx_byte0: got %h/%0d/%0d expected %h/3/1", rec_q[0].data, rec_q[0].strobe, rec_q[0].hold, HDR); end
        end
        repeat (40) @(negedge clk);
        n_checks++; if (rec_q.size() != 1 || state_out !== 3'd1) begin n_fail++; $display("FAIL rx_hold_off: got bytes=%0d state=%0d expected 1/1", rec_q.size(), state_out); end
        rx_busy = 0;
        exp_frames = exp_frames + 16'd1;
        wait_frames(exp_frames, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rx_count: got %0d expected %0d", frames_sent, exp_frames); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (rec_q.size() != 4) begin
            n_fail++; $display("FAIL rx_len: got %0d expected 4", rec_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (rec_q[i].data !== model_byte(cur_sw, i)) begin n_fail++; $display("FAIL rx_byte%0d: got %h expected %h", i, rec_q[i].data, model_byte(cur_sw, i)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] sw_a, sw_b;
        rec_q.delete();
        sw_a = fresh_sw(cur_sw);
        sw_b = fresh_sw(sw_a);
        panel_switches_raw = sw_a;
        wait_busy(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_start: got timeout expected tx_busy=1"); end
        repeat (10) @(negedge clk);
        report_req = 1; @(negedge clk); report_req = 0;
        repeat (5) @(negedge clk);
        panel_switches_raw = sw_b;
        repeat (5) @(negedge clk);
        report_req = 1; @(negedge clk); report_req = 0;
        cur_sw = sw_b;
        exp_frames = exp_frames + 16'd2;
        wait_frames(exp_frames, 400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", frames_sent, exp_frames); end
        repeat (200) @(negedge clk);
        n_checks++; if (frames_sent !== exp_frames) begin n_fail++; $display("FAIL b2b_no_extra: got %0d expected %0d", frames_sent, exp_frames); end
        n_checks++;
        if (rec_q.size() != 8) begin
            n_fail++; $display("FAIL b2b_len: got %0d expected 8", rec_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (rec_q[i].data !== model_byte(i < 4 ? sw_a : sw_b, i % 4)) begin
                    n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rec_q[i].data, model_byte(i < 4 ? sw_a : sw_b, i % 4));
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        rec_q.delete();
        cur_sw = fresh_sw(cur_sw);
        panel_switches_raw = cur_sw;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rec_q.size() == 2 && wr_n === 1'b0) begin ok = 1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_reach: got timeout expected strobe of byte 2"); end
        #2 reset_n = 0;
        #1;
        n_checks++; if (wr_n !== 1'b1 || data_oe !== 1'b0) begin n_fail++; $display("FAIL mid_async: got wr_n=%b oe=%b expected 1/0", wr_n, data_oe); end
        n_checks++; if (frames_sent !== 16'h0000 || tx_busy !== 1'b0 || state_out !== 3'd0) begin n_fail++; $display("FAIL mid_regs: got frames=%0d busy=%b state=%0d expected 0/0/0", frames_sent, tx_busy, state_out); end
        repeat (3) @(negedge clk);
        rec_q.delete();
        reset_n = 1;
        exp_frames = 16'd1;
        wait_frames(exp_frames, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_count: got %0d expected 1", frames_sent); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (rec_q.size() != 4) begin
            n_fail++; $display("FAIL mid_len: got %0d expected 4", rec_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (rec_q[i].data !== model_byte(cur_sw, i)) begin n_fail++; $display("FAIL mid_byte%0d: got %h expected %h", i, rec_q[i].data, model_byte(cur_sw, i)); end
            end
        end
    endtask

    task automatic test_protocol();
        n_checks++; if (bad_strobe != 0) begin n_fail++; $display("FAIL strobe_without_oe: got %0d expected 0", bad_strobe); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_random_frames();
        test_txe_stall();
        test_rx_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
